// File: rtl/uart_tx_palabra.sv
// Serial transmitter for a 32-bit word: four back-to-back 8N1 frames, least-significant byte first.
// All outputs are registered; dbg_state mirrors the FSM state for observation.
module uart_tx_palabra #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] d,
  output logic        ready,
  output logic        busy,
  output logic        tx,
  output logic        done,
  output logic [1:0]  dbg_state
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx_d is the line level for the state being entered, so tx is registered yet cycle-exact.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    baud_d  = baud_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (start) begin
          shift_d = d;
          byte_d  = '0;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START_BIT;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_d = DATA_BITS;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA_BITS: begin
        // After eight shifts the next byte already sits in shift_q[7:0].
        if (bit_end) begin
          shift_d = {1'b0, shift_q[31:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          if (byte_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = START_BIT;
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign tx        = tx_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_palabra.sv
// Bench for uart_tx_palabra: a line decoder scores frames against an expected byte queue,
// while directed vectors and hand sequences check status, done timing and corner cases.
module tb_uart_tx_palabra;

  localparam int CPB       = 4;
  localparam int WORD_CYC  = 40 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] d = '0;
  logic        ready, busy, tx, done;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int frames = 0;

  logic [7:0] exp_q[$];

  uart_tx_palabra #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .start(start), .d(d),
    .ready(ready), .busy(busy), .tx(tx), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset infrastructure
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // line decoder: offset 0 is the first low sample of a start bit
  logic       m_active = 1'b0;
  logic       m_prev = 1'b1;
  int         m_off = 0;
  logic [7:0] m_byte = '0;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (tx === 1'b0 && m_prev === 1'b1) begin
        m_active = 1'b1;
        m_off = 0;
      end
    end else begin
      m_off++;
      if (m_off == 1) begin
        chk("start_bit", {31'b0, tx}, 32'd0);
      end else if (m_off > CPB && m_off <= 1 + 8 * CPB && (m_off - 1) % CPB == 0) begin
        m_byte[(m_off - 1) / CPB - 1] = tx;
      end else if (m_off == 1 + 9 * CPB) begin
        chk("stop_bit", {31'b0, tx}, 32'd1);
        frames++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got byte %h expected no frame", m_byte);
        end else begin
          chk("frame_byte", {24'b0, m_byte}, {24'b0, exp_q.pop_front()});
        end
        m_active = 1'b0;
      end
    end
    m_prev = tx;
  end

  // driver tasks
  task automatic send_word(input logic [31:0] val, output int acc);
    d = val;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    d = $urandom();
    acc = cyc;
    chk("accept_status", {29'b0, busy, ready, tx}, {29'b0, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic wait_done(input int acc, input string name);
    int n = 0;
    while (done !== 1'b1 && n < 3 * WORD_CYC) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, 3 * WORD_CYC);
    end else begin
      chk({name, "_latency"}, cyc - acc, WORD_CYC);
      chk({name, "_done_status"}, {30'b0, ready, busy}, {30'b0, 1'b1, 1'b0});
      @(negedge clk);
      chk({name, "_done_width"}, {31'b0, done}, 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [7:0]  b0, b1, b2, b3;
    logic        poke;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int acc, acc2, dc0, fr0, hi;

    vecs[0] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12, 1'b0};
    vecs[1] = '{32'hA5A5A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b1};
    vecs[2] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 1'b0};
    vecs[3] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80, 1'b1};

    // reset for 3 cycles, then idle line
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("reset_status", {27'b0, dbg_state, tx, ready, busy, done},
        {27'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b1 && ready === 1'b1) hi++;
    end
    chk("idle_tx_high", hi, 20);

    // table-driven words, some with a start pulse while busy
    foreach (vecs[k]) begin
      exp_q.push_back(vecs[k].b0);
      exp_q.push_back(vecs[k].b1);
      exp_q.push_back(vecs[k].b2);
      exp_q.push_back(vecs[k].b3);
      dc0 = done_cnt;
      fr0 = frames;
      send_word(vecs[k].d, acc);
      if (vecs[k].poke) begin
        repeat (30 + 20 * k) @(negedge clk);
        d = 32'hFFFFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("poke_ignored_busy", {31'b0, busy}, 32'd1);
      end
      wait_done(acc, "word");
      repeat (2 * WORD_CYC / 4) @(negedge clk);
      chk("word_frames", frames - fr0, 4);
      chk("word_done_pulses", done_cnt - dc0, 1);
      chk("word_queue_drained", exp_q.size(), 0);
    end

    // start held high: back-to-back words, d re-sampled at the second acceptance
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    fr0 = frames;
    d = 32'h000000FF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    d = 32'h80000001;
    hi = 0;
    while (done !== 1'b1 && hi < 3 * WORD_CYC) begin
      @(negedge clk);
      hi++;
    end
    chk("b2b_first_latency", cyc - acc, WORD_CYC);
    chk("b2b_done_cycle_tx", {31'b0, tx}, 32'd1);
    @(negedge clk);
    acc2 = cyc;
    start = 1'b0;
    chk("b2b_next_start_bit", {29'b0, tx, busy, done}, {29'b0, 1'b0, 1'b1, 1'b0});
    wait_done(acc2, "b2b_second");
    repeat (10) @(negedge clk);
    chk("b2b_frames", frames - fr0, 8);
    chk("b2b_queue_drained", exp_q.size(), 0);

    // reset 50 cycles into a word: only the first frame completes
    exp_q.push_back(8'h21); exp_q.push_back(8'h43); exp_q.push_back(8'h65); exp_q.push_back(8'h87);
    send_word(32'h87654321, acc);
    repeat (49) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midword_reset_status", {27'b0, dbg_state, tx, ready, busy, done},
        {27'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    reset = 1'b1;
    chk("midword_reset_leftover", exp_q.size(), 3);
    exp_q.delete();
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h5A); exp_q.push_back(8'hC3); exp_q.push_back(8'h0F);
    fr0 = frames;
    send_word(32'h0FC35A3C, acc);
    wait_done(acc, "post_reset");
    repeat (5) @(negedge clk);
    chk("post_reset_frames", frames - fr0, 4);
    chk("post_reset_queue", exp_q.size(), 0);

    // reset and start together: reset wins
    fr0 = frames;
    reset = 1'b0;
    start = 1'b1;
    d = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    chk("reset_start_status", {29'b0, tx, ready, busy}, {29'b0, 1'b1, 1'b1, 1'b0});
    reset = 1'b1;
    start = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    chk("reset_start_line_idle", hi, 20);
    chk("reset_start_no_frames", frames - fr0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
